dcache_refill_ctrl: RTL and testbench

- Memory-side miss/refill controller for the pipelined core's 2-way set-associative data cache.
- Watches each CPU load/store against the cache hit flag.
- On a load miss: stalls the pipeline, fetches the word from data memory over a req/ack handshake, writes it into the cache through the cache's fill port, and returns it to the pipeline.
- Stores are write-through with word write-allocate.

---
 rtl/dcache_refill_ctrl_pkg.sv | 27 ++
 rtl/dcache_refill_ctrl_sat_counter.sv | 25 ++
 rtl/dcache_refill_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types and helpers for the data-cache refill path.
// Provides the controller state enum and the word-align helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    FILL      = 2'd3
  } state_e;

  localparam int WORD_OFFSET = 2;

  // Widest address any cache module passes through word_align.
  localparam int ADDR_MAX = 64;

  // Clears the byte-offset bits so the address points at a whole word.
  function automatic logic [ADDR_MAX-1:0] word_align(
    input logic [ADDR_MAX-1:0] a
  );
    logic [ADDR_MAX-1:0] m;
    m = '1;
    m[WORD_OFFSET-1:0] = '0;
    return a & m;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_sat_counter.sv
// Saturating up-counter used for the refill performance counters.
// Ports: clk, rst (async high), i_inc (count enable), o_count (value).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_cnt;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Miss/refill controller for the 2-way data cache: load-miss refill,
// write-through stores, memory timeout, and miss/store counters.
// Ports: CPU side (req_*, cache_hit, cache_rdata, stall, rdata_out),
// cache fill port (fill_*), memory side (mem_*), err, miss/store counts.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  fill_we,
  output logic [DATA_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  store_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_we;
  logic [TW-1:0]         r_tmo;
  logic                  r_err;

  logic                  w_idle;
  logic                  w_busy;
  logic                  w_fill;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_word_addr;
  logic                  w_miss_inc;
  logic                  w_store_inc;

  assign w_idle = (r_state == IDLE);
  assign w_fill = (r_state == FILL);
  assign w_busy = (r_state == MEM_READ) ||
                  (r_state == MEM_WRITE);
  assign w_hit  = w_idle && req_valid &&
                  !req_we && cache_hit;

  assign w_word_addr =
    DATA_WIDTH'(word_align(ADDR_MAX'(r_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid && req_we) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_we    <= 1'b1;
            r_tmo   <= '0;
            r_state <= MEM_WRITE;
          end else if (req_valid && !cache_hit) begin
            r_addr  <= req_addr;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_tmo   <= '0;
            r_state <= MEM_READ;
          end
        end
        MEM_READ, MEM_WRITE: begin
          if (mem_ack) begin
            if (r_state == MEM_READ) begin
              r_rdata <= mem_rdata;
            end
            r_tmo   <= '0;
            r_state <= FILL;
          end else if (r_tmo == TMO_LAST) begin
            // Give up: no fill, sticky error.
            r_err   <= 1'b1;
            r_tmo   <= '0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        FILL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from registered state and latches;
  // only the IDLE hit/miss response looks at the live request.
  always_comb begin
    stall     = 1'b0;
    rdata_out = '0;
    fill_we   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_idle) begin
      stall = req_valid && !w_hit;
      if (w_hit) begin
        rdata_out = cache_rdata;
      end
    end
    if (w_busy) begin
      stall     = 1'b1;
      mem_req   = 1'b1;
      mem_we    = (r_state == MEM_WRITE);
      mem_addr  = w_word_addr;
      mem_wdata = r_wdata;
    end
    if (w_fill) begin
      fill_we   = 1'b1;
      fill_addr = w_word_addr;
      fill_data = r_we ? r_wdata : r_rdata;
      if (!r_we) begin
        rdata_out = r_rdata;
      end
    end
  end

  assign err = r_err;

  assign w_miss_inc  = w_fill && !r_we;
  assign w_store_inc = w_fill && r_we;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_miss_inc),
    .o_count (miss_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_store_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_store_inc),
    .o_count (store_count)
  );

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl.
// Transaction-level model checked every cycle plus literal expectations.
module tb_dcache_refill_ctrl;

  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          cache_hit = 1'b0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] cache_rdata = '0;
  logic [DW-1:0] mem_rdata = '0;

  logic          stall, fill_we, mem_req, mem_we, err;
  logic [DW-1:0] rdata_out, fill_addr, fill_data;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [CW-1:0] miss_count, store_count;

  int n_checks = 0;
  int n_err = 0;

  dcache_refill_ctrl #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .stall       (stall),
    .rdata_out   (rdata_out),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .err         (err),
    .miss_count  (miss_count),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v);
    int n;
    n = int'(v) + 1;
    if (n > (2**CW) - 1) n = (2**CW) - 1;
    return CW'(n);
  endfunction

  // Model: one outstanding operation at most.
  bit            m_op, m_st, m_done, m_err;
  logic [31:0]   m_addr, m_wd, m_rd;
  int            m_wait;
  logic [CW-1:0] m_mc, m_sc;

  always @(negedge clk) begin : model_cmp
    logic        e_stall, e_fill, e_req, e_we, hit;
    logic [31:0] e_rd;
    if (rst) begin
      m_op = 0; m_st = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_wait = 0;
      m_mc = 0; m_sc = 0;
    end
    e_stall = 0; e_fill = 0; e_req = 0;
    e_we = 0; e_rd = 0; hit = 0;
    if (!m_op) begin
      hit = req_valid && !req_we && cache_hit;
      e_stall = req_valid && !hit;
      e_rd = hit ? cache_rdata : 32'h0;
    end else if (!m_done) begin
      e_stall = 1; e_req = 1; e_we = m_st;
    end else begin
      e_fill = 1;
      e_rd = m_st ? 32'h0 : m_rd;
    end
    chk("m_stall", 32'(stall), 32'(e_stall));
    chk("m_rdata_out", rdata_out, e_rd);
    chk("m_fill_we", 32'(fill_we), 32'(e_fill));
    chk("m_mem_req", 32'(mem_req), 32'(e_req));
    chk("m_mem_we", 32'(mem_we), 32'(e_we));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_miss_count", 32'(miss_count), 32'(m_mc));
    chk("m_store_count", 32'(store_count), 32'(m_sc));
    if (e_fill) begin
      chk("m_fill_addr", fill_addr, m_addr & 32'hFFFF_FFFC);
      chk("m_fill_data", fill_data, m_st ? m_wd : m_rd);
    end
    if (e_req) begin
      chk("m_mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
      if (m_st) chk("m_mem_wdata", mem_wdata, m_wd);
    end
    if (!rst) begin
      if (!m_op) begin
        if (req_valid && (req_we || !cache_hit)) begin
          m_op = 1; m_st = req_we; m_done = 0;
          m_addr = req_addr; m_wd = req_wdata; m_wait = 0;
        end
      end else if (!m_done) begin
        if (mem_ack) begin
          m_done = 1; m_rd = mem_rdata;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_err = 1; m_op = 0;
          end
        end
      end else begin
        if (m_st) m_sc = sat_inc(m_sc);
        else m_mc = sat_inc(m_mc);
        m_op = 0;
      end
    end
  end

  // Values captured by xact for literal checks.
  logic [31:0] g_maddr, g_mwdata, g_faddr, g_fdata, g_frd;
  logic        g_mwe, g_fwe, g_fstall, g_freq;

  // Called at posedge+1; returns at posedge+1 of the cycle after FILL.
  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic hit,
                      input int lat, input logic [31:0] rd,
                      output int ns, output int nr);
    ns = 0; nr = 0;
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = wd; cache_hit = hit;
    @(negedge clk);
    ns += int'(stall); nr += int'(mem_req);
    @(posedge clk); #1;
    req_valid = 0; cache_hit = 0;
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        mem_ack = 1; mem_rdata = rd;
      end
      @(negedge clk);
      ns += int'(stall); nr += int'(mem_req);
      if (i == 1) begin
        g_maddr = mem_addr; g_mwe = mem_we;
        g_mwdata = mem_wdata;
      end
      @(posedge clk); #1;
      mem_ack = 0;
    end
    @(negedge clk);
    ns += int'(stall); nr += int'(mem_req);
    g_fwe = fill_we; g_faddr = fill_addr;
    g_fdata = fill_data; g_frd = rdata_out;
    g_fstall = stall; g_freq = mem_req;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ns, nr, nf;

    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_counts", 32'({miss_count, store_count}), 32'h0);
    @(posedge clk); #1 rst = 0;

    // Load hit
    req_valid = 1; req_we = 0; cache_hit = 1;
    req_addr = 32'h40; cache_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("hit_stall", 32'(stall), 32'h0);
    chk("hit_rdata", rdata_out, 32'hDEADBEEF);
    chk("hit_mem_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    req_valid = 0; cache_hit = 0;
    @(negedge clk);
    chk("hit_mem_req2", 32'(mem_req), 32'h0);
    chk("hit_miss_cnt", 32'(miss_count), 32'h0);
    @(posedge clk); #1;

    // Load miss, 3-cycle memory
    xact(0, 32'h106, 32'h0, 0, 3, 32'h12345678, ns, nr);
    chk("miss_stall_cycles", 32'(ns), 32'd4);
    chk("miss_req_cycles", 32'(nr), 32'd3);
    chk("miss_mem_addr", g_maddr, 32'h104);
    chk("miss_mem_we", 32'(g_mwe), 32'h0);
    chk("miss_fill_we", 32'(g_fwe), 32'h1);
    chk("miss_fill_addr", g_faddr, 32'h104);
    chk("miss_fill_data", g_fdata, 32'h12345678);
    chk("miss_fill_rdata", g_frd, 32'h12345678);
    chk("miss_fill_stall", 32'(g_fstall), 32'h0);
    chk("miss_count1", 32'(miss_count), 32'd1);

    // Store, ack after one cycle
    xact(1, 32'h200, 32'hA5A5A5A5, 1, 1, 32'h0, ns, nr);
    chk("st_stall_cycles", 32'(ns), 32'd2);
    chk("st_mem_we", 32'(g_mwe), 32'h1);
    chk("st_mem_wdata", g_mwdata, 32'hA5A5A5A5);
    chk("st_mem_addr", g_maddr, 32'h200);
    chk("st_fill_we", 32'(g_fwe), 32'h1);
    chk("st_fill_data", g_fdata, 32'hA5A5A5A5);
    chk("st_count", 32'(store_count), 32'd1);
    chk("st_miss_same", 32'(miss_count), 32'd1);

    // Back-to-back load misses
    xact(0, 32'h10, 32'h0, 0, 2, 32'h1111_0000, ns, nr);
    chk("b2b1_mem_addr", g_maddr, 32'h10);
    chk("b2b1_no_overlap", 32'(g_freq), 32'h0);
    xact(0, 32'h20, 32'h0, 0, 1, 32'h2222_0000, ns, nr);
    chk("b2b2_mem_addr", g_maddr, 32'h20);
    chk("b2b2_fill_data", g_fdata, 32'h2222_0000);
    chk("b2b2_no_overlap", 32'(g_freq), 32'h0);
    chk("b2b_miss_count", 32'(miss_count), 32'd3);

    // Timeout: no ack
    req_valid = 1; req_we = 0; req_addr = 32'h300;
    cache_hit = 0;
    nr = 0; nf = 0;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nr += int'(mem_req); nf += int'(fill_we);
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", 32'(nr), 32'd8);
    chk("tmo_fill_cycles", 32'(nf), 32'd0);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_idle_stall", 32'(stall), 32'h0);
    chk("tmo_miss_count", 32'(miss_count), 32'd3);
    // err stays set across later activity
    req_valid = 1; cache_hit = 1; cache_rdata = 32'h55;
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 32'h1);
    @(posedge clk); #1;
    req_valid = 0; cache_hit = 0;

    // Reset two cycles into MEM_READ
    req_valid = 1; req_we = 0; req_addr = 32'h400;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    #2 rst = 1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_counts", 32'({miss_count, store_count}), 32'h0);
    @(posedge clk); #1 rst = 0;
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 mem_ack = 0;
    @(negedge clk);
    chk("late_ack_fill", 32'(fill_we), 32'h0);
    chk("late_ack_req", 32'(mem_req), 32'h0);
    chk("late_ack_miss", 32'(miss_count), 32'h0);
    @(posedge clk); #1;

    // Store counter saturation (4-bit)
    for (int i = 0; i < 15; i++)
      xact(1, 32'(i * 4), 32'(i), 0, 1, 32'h0, ns, nr);
    chk("sat_at_max", 32'(store_count), 32'd15);
    xact(1, 32'h80, 32'h7, 0, 1, 32'h0, ns, nr);
    chk("sat_hold", 32'(store_count), 32'd15);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
